// File: rtl/keypad_entry.sv
// keypad_entry: debounce, encode and accumulate keypad digits for the
// microwave controller timer load path.
//
// A 10-bit one-hot keypad is debounced by a four-state FSM
// (IDLE / DEBOUNCE / HELD / RELEASE). Each accepted press is encoded to BCD.
// Unless lock is high, each accepted press is also shifted into a 3-digit
// entry register (mins <- tens <- ones <- new key).
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive identical samples needed to accept a press
//                    or a release (>= 1)
//
// Ports:
//   clock        system clock, rising edge
//   clearn       asynchronous active-low reset
//   keypad[9:0]  one-hot keypad, bit i = key i
//   lock         freezes the entry register; presses are still reported
//   clear_entry  synchronous clear of entry digits and digit count
//   key_pulse    one-cycle strobe per accepted press
//   key_code     BCD code of the last accepted key
//   ones/tens/mins  entry digits (seconds ones, seconds tens, minutes)
//   digit_count  digits entered since clear, saturating at 3
//
// Build option:
//   KEYPAD_SYNC_EN  adds a 2-flop synchronizer on keypad (+2 cycles latency)
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [9:0] keypad,
  input  logic       lock,
  input  logic       clear_entry,
  output logic       key_pulse,
  output logic [3:0] key_code,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] mins,
  output logic [1:0] digit_count
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    cand_code, cand_code_nxt;
  logic [9:0]    kp;
  logic [3:0]    enc;
  logic          valid;
  logic          kp_zero;
  logic          accept;

`ifdef KEYPAD_SYNC_EN
  logic [9:0] sync_q1, sync_q2;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= keypad;
      sync_q2 <= sync_q1;
    end
  end

  assign kp = sync_q2;
`else
  assign kp = keypad;
`endif

  // Zero or several keys at once are treated as "no key".
  assign valid   = $onehot(kp);
  assign kp_zero = (kp == '0);
  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (kp[i]) enc = 4'(i);
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state     <= IDLE;
      cnt       <= '0;
      cand_code <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand_code <= cand_code_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cand_code_nxt = cand_code;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          cand_code_nxt = enc;
          cnt_nxt       = CW'(1);
          if (DEBOUNCE_CYCLES == 1) begin
            accept    = 1'b1;
            state_nxt = HELD;
          end else begin
            state_nxt = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (valid && (enc == cand_code)) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == DB_TARGET) begin
            accept    = 1'b1;
            state_nxt = HELD;
          end
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      HELD: begin
        // The first zero sample already counts toward the release run.
        if (kp_zero) begin
          cnt_nxt = CW'(1);
          if (DEBOUNCE_CYCLES == 1) state_nxt = IDLE;
          else                      state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!kp_zero) begin
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == DB_TARGET) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // On an accept the current sample equals the candidate, so enc is the key.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      key_pulse   <= 1'b0;
      key_code    <= '0;
      ones        <= '0;
      tens        <= '0;
      mins        <= '0;
      digit_count <= '0;
    end else begin
      key_pulse <= accept;
      if (accept) key_code <= enc;
      if (clear_entry) begin
        ones        <= '0;
        tens        <= '0;
        mins        <= '0;
        digit_count <= '0;
      end else if (accept && !lock) begin
        mins <= tens;
        tens <= ones;
        ones <= enc;
        if (digit_count != 2'd3) digit_count <= digit_count + 2'd1;
      end
    end
  end

endmodule
